// File: rtl/sram_mport_ctrl.sv
// Multi-channel controller for a single asynchronous 16-bit SRAM.
// Arbitrates NCH requesters and runs one strobed read or write at a time.
module sram_mport_ctrl #(
    parameter int NCH      = 2,
    parameter int AW       = 18,
    parameter int DW       = 16,
    parameter int WAIT_CYC = 1,
    parameter int RR_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    wr,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    done,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic [AW-1:0]     sram_addr,
    inout  wire  [DW-1:0]     sram_data,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_en_n,
    output logic [1:0]        state_out
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [GW-1:0]  grant;
    logic [GW-1:0]  grant_nx;
    logic [GW-1:0]  rr_ptr;
    logic           found;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] eligible;
    logic           wr_lat;
    logic [AW-1:0]  addr_lat;
    logic [DW-1:0]  wdata_lat;
    logic [3:0]     wait_cnt;
    logic           last_access;
    logic           drive;
    logic           wr_cur;
    logic [AW-1:0]  addr_arr  [NCH];
    logic [DW-1:0]  wdata_arr [NCH];

    assign last_access = (wait_cnt == 4'(WAIT_CYC - 1));
    assign state_out   = state;
    assign sram_data   = drive ? wdata_lat : {DW{1'bz}};

    // Channel arbitration; the search origin is the round-robin pointer when enabled.
    always_comb begin
        int idx;
        idx      = 0;
        eligible = req & ~mask;
        found    = 1'b0;
        grant_nx = '0;
        for (int k = 0; k < NCH; k++) begin
            addr_arr[k]  = addr[k*AW +: AW];
            wdata_arr[k] = wdata[k*DW +: DW];
        end
        for (int k = 0; k < NCH; k++) begin
            idx = (RR_MODE != 0) ? ((int'(rr_ptr) + k) % NCH) : k;
            if (!found && eligible[GW'(idx)]) begin
                found    = 1'b1;
                grant_nx = GW'(idx);
            end
        end
    end

    always_comb begin
        state_nx = state;
        wr_cur   = (state == IDLE) ? wr[grant_nx] : wr_lat;
        case (state)
            IDLE:    if (found) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (last_access) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            mask      <= '0;
            wr_lat    <= 1'b0;
            addr_lat  <= '0;
            wdata_lat <= '0;
            wait_cnt  <= '0;
            done      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            sram_addr <= '0;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_en_n <= 1'b1;
            drive     <= 1'b0;
        end else begin
            state     <= state_nx;
            done      <= '0;
            mask      <= '0;
            busy      <= (state_nx != IDLE);
            sram_en_n <= (state_nx == IDLE);
            sram_oe_n <= !((state_nx == ACCESS) && !wr_cur);
            sram_we_n <= !((state_nx == ACCESS) && wr_cur);
            drive     <= (state_nx != IDLE) && wr_cur;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= grant_nx;
                        wr_lat    <= wr[grant_nx];
                        addr_lat  <= addr_arr[grant_nx];
                        wdata_lat <= wdata_arr[grant_nx];
                        sram_addr <= addr_arr[grant_nx];
                        if (RR_MODE != 0) begin
                            rr_ptr <= (int'(grant_nx) == NCH - 1) ? '0 : grant_nx + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (last_access) begin
                        wait_cnt    <= '0;
                        done[grant] <= 1'b1;
                        if (!wr_lat) rdata <= sram_data;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                FINISH: begin
                    // Block an immediate re-grant while the finished requester is still dropping req.
                    mask[grant] <= 1'b1;
                    sram_addr   <= addr_lat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mport_ctrl.sv
// Scoreboard bench for sram_mport_ctrl: a fixed-priority 2-channel instance (WAIT_CYC=1)
// and a round-robin 3-channel instance (WAIT_CYC=3), each with its own SRAM model.
module tb_sram_mport_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;

    typedef struct {
        int          ch;
        logic        rd;
        logic [15:0] data;
        int          due;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    logic started = 1'b0;

    sb_t q_a[$];
    sb_t q_b[$];
    sb_t ea;
    sb_t eb;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    logic [1:0]      a_req = '0, a_wr = '0, a_done;
    logic [2*AW-1:0] a_addr = '0;
    logic [2*DW-1:0] a_wdata = '0;
    logic [DW-1:0]   a_rdata;
    logic            a_busy, a_oe_n, a_we_n, a_en_n;
    logic [AW-1:0]   a_sram_addr;
    logic [1:0]      a_state;
    wire  [DW-1:0]   a_sram_data;

    logic [2:0]      b_req = '0, b_wr = '0, b_done;
    logic [3*AW-1:0] b_addr = '0;
    logic [3*DW-1:0] b_wdata = '0;
    logic [DW-1:0]   b_rdata;
    logic            b_busy, b_oe_n, b_we_n, b_en_n;
    logic [AW-1:0]   b_sram_addr;
    logic [1:0]      b_state;
    wire  [DW-1:0]   b_sram_data;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    sram_mport_ctrl #(.NCH(2), .AW(AW), .DW(DW), .WAIT_CYC(1), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .wr(a_wr), .addr(a_addr), .wdata(a_wdata),
        .done(a_done), .rdata(a_rdata), .busy(a_busy), .sram_addr(a_sram_addr),
        .sram_data(a_sram_data), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n),
        .sram_en_n(a_en_n), .state_out(a_state)
    );

    sram_mport_ctrl #(.NCH(3), .AW(AW), .DW(DW), .WAIT_CYC(3), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .wr(b_wr), .addr(b_addr), .wdata(b_wdata),
        .done(b_done), .rdata(b_rdata), .busy(b_busy), .sram_addr(b_sram_addr),
        .sram_data(b_sram_data), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
        .sram_en_n(b_en_n), .state_out(b_state)
    );

    // Asynchronous SRAM models: drive on read strobe, store while the write strobe is low.
    assign a_sram_data = (!a_en_n && !a_oe_n) ? mem_a[a_sram_addr[7:0]] : 16'bz;
    assign b_sram_data = (!b_en_n && !b_oe_n) ? mem_b[b_sram_addr[7:0]] : 16'bz;

    always @(negedge clk) begin
        if (!a_en_n && !a_we_n) mem_a[a_sram_addr[7:0]] = a_sram_data;
        if (!b_en_n && !b_we_n) mem_b[b_sram_addr[7:0]] = b_sram_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input int inst, input int ch, input logic w,
                                 input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        if (inst == 0) begin
            a_wr[ch] = w;
            a_addr[ch*AW +: AW] = ad;
            a_wdata[ch*DW +: DW] = wd;
            a_req[ch] = 1'b1;
        end else begin
            b_wr[ch] = w;
            b_addr[ch*AW +: AW] = ad;
            b_wdata[ch*DW +: DW] = wd;
            b_req[ch] = 1'b1;
        end
    endtask

    task automatic push_expected(input int inst, input int ch, input logic rd,
                                 input logic [15:0] d, input int due);
        sb_t e;
        e.ch = ch; e.rd = rd; e.data = d; e.due = due;
        if (inst == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    // Waits for one channel's done, counting strobe and bus activity, then drops req like a
    // requester that only reacts a full cycle after the masked IDLE cycle.
    task automatic wait_done(input int inst, input int ch, input logic [15:0] wd,
                             output int oe_low, output int we_low, output int data_hits);
        int   n = 0;
        logic hit = 1'b0;
        oe_low = 0; we_low = 0; data_hits = 0;
        while (!hit && n < 40) begin
            @(negedge clk);
            n++;
            if (inst == 0) begin
                if (!a_oe_n) oe_low++;
                if (!a_we_n) we_low++;
                if (a_sram_data === wd) data_hits++;
                hit = a_done[ch];
            end else begin
                if (!b_oe_n) oe_low++;
                if (!b_we_n) we_low++;
                if (b_sram_data === wd) data_hits++;
                hit = b_done[ch];
            end
        end
        checkOutput("done_seen", 32'(hit), 32'd1);
        @(negedge clk);
        @(negedge clk);
        if (inst == 0) a_req[ch] = 1'b0;
        else b_req[ch] = 1'b0;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (started) begin
            if (a_done != 2'b00) begin
                if (q_a.size() == 0) begin
                    checkOutput("a_unexpected_done", 32'(a_done), 32'd0);
                end else begin
                    ea = q_a.pop_front();
                    checkOutput("a_done_chan", 32'(a_done), 32'd1 << ea.ch);
                    checkOutput("a_done_cycle", cycle, ea.due);
                    if (ea.rd) checkOutput("a_rdata", 32'(a_rdata), 32'(ea.data));
                end
            end
            if (b_done != 3'b000) begin
                if (q_b.size() == 0) begin
                    checkOutput("b_unexpected_done", 32'(b_done), 32'd0);
                end else begin
                    eb = q_b.pop_front();
                    checkOutput("b_done_chan", 32'(b_done), 32'd1 << eb.ch);
                    checkOutput("b_done_cycle", cycle, eb.due);
                    if (eb.rd) checkOutput("b_rdata", 32'(b_rdata), 32'(eb.data));
                end
            end
        end
    end

    initial begin
        int c, oe, we, hits, seen, n;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
        end
        mem_a[8'h23] = 16'hBEEF;
        mem_a[8'h50] = 16'h1111;
        mem_a[8'h60] = 16'h2222;
        mem_a[8'h40] = 16'h5A5A;
        mem_b[8'h01] = 16'hA001;
        mem_b[8'h02] = 16'hA002;
        mem_b[8'h03] = 16'hA003;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_a_state", 32'(a_state), 32'd0);
        checkOutput("rst_a_strobes", {29'd0, a_oe_n, a_we_n, a_en_n}, 32'd7);
        checkOutput("rst_a_busy", 32'(a_busy), 32'd0);
        checkOutput("rst_a_done", 32'(a_done), 32'd0);
        checkOutput("rst_a_rdata", 32'(a_rdata), 32'd0);
        checkOutput("rst_a_addr", 32'(a_sram_addr), 32'd0);
        checkOutput("rst_b_state", 32'(b_state), 32'd0);
        checkOutput("rst_b_strobes", {29'd0, b_oe_n, b_we_n, b_en_n}, 32'd7);
        rst = 1'b0;
        started = 1'b1;

        // Reset in the middle of a write must abort without a done pulse.
        @(negedge clk); c = cycle;
        applyStimulus(0, 0, 1'b1, 18'h00099, 16'hDEAD);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t1_state_access", 32'(a_state), 32'd2);
        checkOutput("t1_we_low", 32'(a_we_n), 32'd0);
        rst = 1'b1;
        a_req = '0;
        @(negedge clk);
        checkOutput("t1_state_idle", 32'(a_state), 32'd0);
        checkOutput("t1_strobes", {29'd0, a_oe_n, a_we_n, a_en_n}, 32'd7);
        checkOutput("t1_busy", 32'(a_busy), 32'd0);
        checkOutput("t1_addr", 32'(a_sram_addr), 32'd0);
        rst = 1'b0;

        // Round-robin with all three channels held: order 0,1,2,0.
        @(negedge clk); c = cycle;
        applyStimulus(1, 0, 1'b0, 18'h00001, 16'h0);
        applyStimulus(1, 1, 1'b0, 18'h00002, 16'h0);
        applyStimulus(1, 2, 1'b0, 18'h00003, 16'h0);
        push_expected(1, 0, 1'b1, 16'hA001, c + 5);
        push_expected(1, 1, 1'b1, 16'hA002, c + 11);
        push_expected(1, 2, 1'b1, 16'hA003, c + 17);
        push_expected(1, 0, 1'b1, 16'hA001, c + 23);
        seen = 0; n = 0;
        while (seen < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (b_done != 3'b000) seen++;
        end
        checkOutput("t5_all_served", seen, 32'd4);
        @(negedge clk);
        b_req = '0;

        // Write with a 3-cycle strobe.
        @(negedge clk); c = cycle;
        applyStimulus(1, 0, 1'b1, 18'h00010, 16'h1234);
        push_expected(1, 0, 1'b0, 16'h0, c + 5);
        wait_done(1, 0, 16'h1234, oe, we, hits);
        checkOutput("t3_we_low_cycles", we, 32'd3);
        checkOutput("t3_oe_low_cycles", oe, 32'd0);
        checkOutput("t3_data_stable", hits, 32'd5);
        checkOutput("t3_mem", 32'(mem_b[8'h10]), 32'h1234);

        // Single read on channel 1.
        @(negedge clk); c = cycle;
        applyStimulus(0, 1, 1'b0, 18'h00123, 16'h0);
        push_expected(0, 1, 1'b1, 16'hBEEF, c + 3);
        wait_done(0, 1, 16'h0, oe, we, hits);
        checkOutput("t2_oe_low_cycles", oe, 32'd1);
        checkOutput("t2_we_low_cycles", we, 32'd0);
        checkOutput("t2_rdata_hold", 32'(a_rdata), 32'hBEEF);

        // Simultaneous requests under fixed priority.
        @(negedge clk); c = cycle;
        applyStimulus(0, 0, 1'b0, 18'h00050, 16'h0);
        applyStimulus(0, 1, 1'b0, 18'h00060, 16'h0);
        push_expected(0, 0, 1'b1, 16'h1111, c + 3);
        push_expected(0, 1, 1'b1, 16'h2222, c + 7);
        wait_done(0, 0, 16'h0, oe, we, hits);
        wait_done(0, 1, 16'h0, oe, we, hits);

        // Address changes after grant must not reach the pins.
        @(negedge clk); c = cycle;
        applyStimulus(0, 0, 1'b0, 18'h00040, 16'h0);
        push_expected(0, 0, 1'b1, 16'h5A5A, c + 3);
        @(negedge clk);
        @(negedge clk);
        a_addr[AW-1:0] = 18'h00077;
        checkOutput("t6_addr_access", 32'(a_sram_addr), 32'h40);
        @(negedge clk);
        checkOutput("t6_addr_finish", 32'(a_sram_addr), 32'h40);
        @(negedge clk);
        @(negedge clk);
        a_req[0] = 1'b0;

        repeat (6) @(negedge clk);
        checkOutput("a_pending", q_a.size(), 32'd0);
        checkOutput("b_pending", q_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
